// File: rtl/chi_iter_unit.sv
// Iterative Keccak chi engine: transforms PLANES_PER_CYCLE planes of a 5x5xLANE_W
// state per clock in place, with valid/ready handshakes on both sides.
module chi_iter_unit #(
  parameter int LANE_W           = 64,
  parameter int PLANES_PER_CYCLE = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic                           bypass_i,
  input  logic [4:0][4:0][LANE_W-1:0]    state_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [4:0][4:0][LANE_W-1:0]    state_o,
  output logic                           busy_o
);

  if (!(LANE_W == 1 || LANE_W == 2 || LANE_W == 4 || LANE_W == 8 ||
        LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
    $error("chi_iter_unit: LANE_W must be a power of two in 1..64");
  end
  if (PLANES_PER_CYCLE < 1 || PLANES_PER_CYCLE > 5) begin : g_bad_ppc
    $error("chi_iter_unit: PLANES_PER_CYCLE must be in 1..5");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef logic [4:0][LANE_W-1:0] plane_t;

  state_t                        r_state, w_state_nxt;
  logic [2:0]                    r_cnt, w_cnt_nxt;
  logic [4:0][4:0][LANE_W-1:0]   r_buf, w_buf_nxt;

  // chi on one plane, indexed by x
  function automatic plane_t chi_plane(input plane_t p);
    plane_t r;
    for (int x = 0; x < 5; x++) begin
      r[x] = p[x] ^ (~p[(x + 1) % 5] & p[(x + 2) % 5]);
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_buf_nxt   = state_i;
          w_cnt_nxt   = '0;
          w_state_nxt = bypass_i ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        busy_o = 1'b1;
        // Planes past y=4 in the final window are skipped when P does not divide 5
        for (int k = 0; k < PLANES_PER_CYCLE; k++) begin
          logic [3:0] ysum;
          plane_t     pin;
          plane_t     pout;
          pin  = '0;
          pout = '0;
          ysum = {1'b0, r_cnt} + 4'(k);
          if (ysum < 4'd5) begin
            for (int x = 0; x < 5; x++) pin[x] = r_buf[x][ysum[2:0]];
            pout = chi_plane(pin);
            for (int x = 0; x < 5; x++) w_buf_nxt[x][ysum[2:0]] = pout[x];
          end
        end
        if (({1'b0, r_cnt} + 4'(PLANES_PER_CYCLE)) >= 4'd5) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 3'(PLANES_PER_CYCLE);
        end
      end
      S_DONE: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign state_o = r_buf;

endmodule

// File: tb/tb_chi_iter_unit.sv
// Bench for chi_iter_unit: five LANE_W=64 instances (P=1..5) plus one LANE_W=8, P=5
// instance, driven by directed steps with a scoreboard queue of expected results.
module tb_chi_iter_unit;

  typedef logic [4:0][4:0][63:0] st64_t;
  typedef logic [4:0][4:0][7:0]  st8_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    last_acc = 0;
  st64_t exp_q [$];

  logic  in_valid [5];
  logic  in_ready [5];
  logic  bypass [5];
  logic  out_valid [5];
  logic  out_ready [5];
  logic  busy [5];
  st64_t st_in [5];
  st64_t st_out [5];

  logic  in_valid8, in_ready8, bypass8, out_valid8, out_ready8, busy8;
  st8_t  st_in8, st_out8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    chi_iter_unit #(.LANE_W(64), .PLANES_PER_CYCLE(g + 1)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid[g]),
      .in_ready_o (in_ready[g]),
      .bypass_i   (bypass[g]),
      .state_i    (st_in[g]),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready[g]),
      .state_o    (st_out[g]),
      .busy_o     (busy[g])
    );
  end

  chi_iter_unit #(.LANE_W(8), .PLANES_PER_CYCLE(5)) u_w8 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid8),
    .in_ready_o (in_ready8),
    .bypass_i   (bypass8),
    .state_i    (st_in8),
    .out_valid_o(out_valid8),
    .out_ready_i(out_ready8),
    .state_o    (st_out8),
    .busy_o     (busy8)
  );

  function automatic st64_t chi_model(input st64_t a);
    st64_t r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[x][y] = a[x][y] ^ (~a[(x + 1) % 5][y] & a[(x + 2) % 5][y]);
    return r;
  endfunction

  function automatic st64_t rand_state();
    st64_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = {$urandom(), $urandom()};
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input st64_t obs, input st64_t exp);
    int bx, by;
    bx = 0;
    by = 0;
    for (int x = 4; x >= 0; x--)
      for (int y = 4; y >= 0; y--)
        if (obs[x][y] !== exp[x][y]) begin
          bx = x;
          by = y;
        end
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: lane(%0d,%0d) observed %h expected %h", tag, bx, by,
             obs[bx][by], exp[bx][by]);
    end
  endtask

  task automatic chk_state8(input string tag, input st8_t obs, input st8_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with instance g idle; returns at a negedge with it idle again.
  task automatic txn(input int g, input st64_t s, input bit byp, input int stall,
                     input bit noise, input int exp_gap);
    int    n, lat;
    st64_t held, exp;
    n = (5 + g) / (g + 1);
    chk1("in_ready_idle", in_ready[g], 1'b1);
    in_valid[g] = 1'b1;
    bypass[g]   = byp;
    st_in[g]    = s;
    exp_q.push_back(byp ? s : chi_model(s));
    if (exp_gap > 0) chkn("throughput", cyc - last_acc, exp_gap);
    last_acc = cyc;
    @(negedge clk);
    in_valid[g] = noise;
    bypass[g]   = 1'b0;
    if (noise) st_in[g] = rand_state();
    lat = 1;
    while (!out_valid[g] && lat < 40) begin
      chk1("in_ready_busy", in_ready[g], 1'b0);
      chk1("busy_flag", busy[g], 1'b1);
      @(negedge clk);
      lat++;
    end
    in_valid[g] = 1'b0;
    chkn("latency", lat, byp ? 1 : n + 1);
    chk1("in_ready_done", in_ready[g], 1'b0);
    held = st_out[g];
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk1("stall_valid", out_valid[g], 1'b1);
      chk_state("stall_hold", st_out[g], held);
    end
    exp = exp_q.pop_front();
    chk_state("result", st_out[g], exp);
    out_ready[g] = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
    chk1("valid_after_hs", out_valid[g], 1'b0);
    chk1("ready_after_hs", in_ready[g], 1'b1);
  endtask

  initial begin
    st64_t s;
    st8_t  s8, e8;
    int    lat;

    for (int g = 0; g < 5; g++) begin
      in_valid[g]  = 1'b0;
      bypass[g]    = 1'b0;
      out_ready[g] = 1'b0;
      st_in[g]     = '0;
    end
    in_valid8  = 1'b0;
    bypass8    = 1'b0;
    out_ready8 = 1'b0;
    st_in8     = '0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);

    for (int g = 0; g < 5; g++) begin
      chk1("rst_out_valid", out_valid[g], 1'b0);
      chk1("rst_in_ready", in_ready[g], 1'b1);
      chk1("rst_busy", busy[g], 1'b0);
      chk_state("rst_state", st_out[g], '0);
    end
    chk_state8("rst_state8", st_out8, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // all-zero state, in_valid held high with noise during BUSY
    txn(0, '0, 1'b0, 0, 1'b1, 0);

    // plane 0 with only lane x=1 set
    s = '0;
    s[1][0] = '1;
    txn(0, s, 1'b0, 0, 1'b0, 0);

    // LANE_W=8, P=5
    s8 = '0;
    s8[2][3] = 8'h0F;
    e8 = '0;
    e8[0][3] = 8'h0F;
    e8[2][3] = 8'h0F;
    chk1("w8_in_ready", in_ready8, 1'b1);
    in_valid8 = 1'b1;
    st_in8    = s8;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chkn("w8_latency", lat, 2);
    chk_state8("w8_result", st_out8, e8);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk1("w8_idle", out_valid8, 1'b0);

    // all ones through chi, then random state bypassed
    txn(0, '1, 1'b0, 0, 1'b0, 0);
    txn(0, rand_state(), 1'b1, 0, 1'b0, 0);
    txn(0, rand_state(), 1'b1, 0, 1'b0, 2);

    // random states with a 10-cycle stall, then back-to-back pairs
    for (int g = 0; g < 5; g++) begin
      txn(g, rand_state(), 1'b0, 10, 1'b0, 0);
      txn(g, rand_state(), 1'b0, 0, 1'b0, 0);
      txn(g, rand_state(), 1'b0, 0, 1'b0, (5 + g) / (g + 1) + 2);
    end

    // reset during the second BUSY cycle of P=1
    in_valid[0] = 1'b1;
    st_in[0]    = rand_state();
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk1("midrst_out_valid", out_valid[0], 1'b0);
    chk1("midrst_in_ready", in_ready[0], 1'b1);
    chk1("midrst_busy", busy[0], 1'b0);
    chk_state("midrst_state", st_out[0], '0);
    txn(0, rand_state(), 1'b0, 3, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chi_iter_unit.md
Name: chi_iter_unit

Overview:
Multi-cycle, parametrised Keccak χ (chi) engine with valid/ready handshakes on input and output. It accepts a full 5x5xLANE_W state, applies A'[x,y] = A[x,y] XOR (NOT A[(x+1) mod 5,y] AND A[(x+2) mod 5,y]) to PLANES_PER_CYCLE planes (y-rows) per clock, and holds the result until the consumer takes it. It sits in the round datapath between the π stage and the ι stage. It lets area-constrained builds trade χ logic for latency, and supports Keccak-f widths below 1600 bits.

Parameters:
LANE_W, 64, lane width in bits; legal values 1, 2, 4, 8, 16, 32, 64 (Keccak-f[25*LANE_W]).
PLANES_PER_CYCLE, 1, planes transformed per BUSY cycle; legal range 1..5.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_ni  input  1  synchronous reset, active-low.
in_valid_i  input  1  input state valid.
in_ready_o  output  1  unit can accept a state.
bypass_i  input  1  sampled with the input state; 1 = pass the state through unchanged.
state_i  input  5x5xLANE_W  input state, indexed [x][y][z].
out_valid_o  output  1  result valid.
out_ready_i  input  1  consumer accepts the result.
state_o  output  5x5xLANE_W  result state, indexed [x][y][z].
busy_o  output  1  high in BUSY or DONE.

Behaviour:
- Reset (rst_ni=0 at a rising edge):
  - FSM goes to IDLE; plane counter = 0.
  - State buffer cleared to all zeros.
  - out_valid_o=0, in_ready_o=1, busy_o=0, state_o=0.
  - Reset overrides every other input, including during BUSY or DONE; any in-flight state is discarded.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i=1, the buffer captures state_i and bypass_i is latched.
  - bypass=0 -> next state BUSY, plane counter = 0.
  - bypass=1 -> next state DONE.
- BUSY:
  - Each cycle, planes y = cnt .. min(cnt+PLANES_PER_CYCLE, 5)-1 in the buffer are replaced by their χ result.
  - The χ result uses only lanes of the same plane, so in-place update is safe.
  - cnt advances by PLANES_PER_CYCLE.
  - After the cycle that processes plane 4, go to DONE.
  - Number of BUSY cycles N = ceil(5/PLANES_PER_CYCLE): P=1 -> 5, P=2 -> 3, P=3 -> 2, P=4 -> 2 (second cycle processes plane 4 only), P=5 -> 1.
  - in_valid_i is ignored; in_ready_o=0.
- DONE:
  - out_valid_o=1; state_o reflects the buffer.
  - On out_ready_i=1 -> IDLE.
  - out_valid_o and state_o are held stable while out_ready_i=0, with no limit on stall length.
- Outputs:
  - state_o is driven from the buffer register at all times (registered output).
  - in_ready_o is high only in IDLE and is a function of state only; no combinational path from out_ready_i.
  - A new state can therefore be accepted on the cycle after the output handshake. Throughput is one state per N+2 cycles (bypass: one per 2 cycles).
- Latency, counted from the input handshake edge to out_valid_o=1: N+1 cycles for χ, 1 cycle for bypass.
- Lane arithmetic is purely bitwise per z. There are no carries or rotations, so LANE_W affects width only.
- Simultaneous events:
  - in_valid_i=1 during BUSY/DONE is not accepted; the producer must hold it.
  - out_ready_i=1 outside DONE has no effect.
- Unused buffer positions do not exist for legal LANE_W. Illegal parameters trigger an elaboration-time $error.

Test Plan:
- Reset then all-zero state, P=1, LANE_W=64 -> out_valid_o rises 6 cycles after the input handshake; state_o all zeros; in_ready_o=0 throughout BUSY/DONE.
- Plane y=0 with only lane x=1 = all ones, all else zero, LANE_W=64, P=1 -> state_o lanes (1,0) and (4,0) = all ones; every other lane = 0.
- LANE_W=8, P=5: lane (2,3)=0x0F, all else zero -> lanes (0,3) and (2,3) = 0x0F, others 0x00; out_valid_o exactly 2 cycles after the handshake.
- All-ones state with bypass_i=0, then random state with bypass_i=1 -> first result all ones; second result equals the input bit-exactly, out_valid_o 1 cycle after the handshake.
- Random states against a golden χ model for P in {1,2,3,4,5} with out_ready_i held low 10 cycles in DONE -> results match; state_o stable during the stall; back-to-back throughput of N+2 cycles per state.
- rst_ni=0 asserted in BUSY cycle 2 (P=1) -> next cycle IDLE, out_valid_o=0, state_o=0; a following transaction completes correctly.
